// File: rtl/sif_regbank_pkg.sv
// sif_regbank_pkg: shared widths, types and helpers for the SIF register bank
package sif_regbank_pkg;
    localparam int SIF_ADDR_W = 16;
    localparam int SIF_DATA_W = 16;
    typedef logic [SIF_ADDR_W-1:0] sif_addr_t;
    typedef logic [SIF_DATA_W-1:0] sif_data_t;
    typedef struct packed {
        sif_addr_t addr;
        sif_data_t data;
    } sif_wr_req_t;
    function automatic logic in_range(input logic [31:0] a, input int depth);
        return a < 32'(depth);
    endfunction
endpackage

// File: rtl/sif_regbank_if.sv
// sif_regbank_if: X read/write agent and NUM_W write-only W agents of the register bank
interface sif_regbank_if
    import sif_regbank_pkg::*;
#(
    parameter int NUM_W  = 2,
    parameter int ADDR_W = SIF_ADDR_W,
    parameter int DATA_W = SIF_DATA_W
);
    logic                         xa_wr_s;
    logic                         xa_rd_s;
    logic [ADDR_W-1:0]            xa_addr;
    logic [DATA_W-1:0]            xa_data_wr;
    logic [DATA_W-1:0]            xa_data_rd;
    logic                         xa_rd_vld;
    logic                         xa_err;
    logic [NUM_W-1:0]             wa_wr_s;
    logic [NUM_W-1:0][ADDR_W-1:0] wa_addr;
    logic [NUM_W-1:0][DATA_W-1:0] wa_data_wr;
    logic [NUM_W-1:0]             wa_busy;
    modport master (
        output xa_wr_s, xa_rd_s, xa_addr, xa_data_wr, wa_wr_s, wa_addr, wa_data_wr,
        input  xa_data_rd, xa_rd_vld, xa_err, wa_busy
    );
    modport slave (
        input  xa_wr_s, xa_rd_s, xa_addr, xa_data_wr, wa_wr_s, wa_addr, wa_data_wr,
        output xa_data_rd, xa_rd_vld, xa_err, wa_busy
    );
endinterface

// File: rtl/sif_regbank_rr_arb.sv
// sif_rr_arb: round-robin one-hot arbiter, searches upward from a rotating pointer
module sif_rr_arb #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);
    localparam int PW = N > 1 ? $clog2(N) : 1;
    logic [PW-1:0] ptr, nxt, idx;
    logic          found;
    // first requester at or above the pointer wins; pointer moves just past it
    always_comb begin
        gnt   = '0;
        nxt   = ptr;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = en;
                nxt      = PW'((int'(idx) + 1) % N);
            end
        end
    end
    // pointer only advances on an actual grant
    always_ff @(posedge clk) begin
        if (rst) ptr <= '0;
        else if (en && found) ptr <= nxt;
    end
endmodule

// File: rtl/sif_regbank.sv
// sif_regbank: X read/write + NUM_W W write-only register bank; optional SIF_REGBANK_WR_FWD_EN forwards same-edge writes to reads
module sif_regbank
    import sif_regbank_pkg::*;
#(
    parameter int NUM_W  = 2,
    parameter int ADDR_W = SIF_ADDR_W,
    parameter int DATA_W = SIF_DATA_W,
    parameter int DEPTH  = 64
) (
    input logic          clk,
    input logic          rst,
    sif_regbank_if.slave bus
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [DATA_W-1:0]            mem [DEPTH];
    logic [NUM_W-1:0][ADDR_W-1:0] hold_addr;
    logic [NUM_W-1:0][DATA_W-1:0] hold_data;
    logic [NUM_W-1:0]             busy, gnt;
    logic [ADDR_W-1:0]            w_addr, wr_addr;
    logic [DATA_W-1:0]            w_data, wr_data, rd_val;
    logic                         x_in, w_in, w_act, we;

    assign bus.wa_busy = busy;
    assign x_in        = in_range(32'(bus.xa_addr), DEPTH);
    assign w_in        = in_range(32'(w_addr), DEPTH);
    assign we          = (bus.xa_wr_s && x_in) || (w_act && w_in);
    assign wr_addr     = bus.xa_wr_s ? bus.xa_addr : w_addr;
    assign wr_data     = bus.xa_wr_s ? bus.xa_data_wr : w_data;

    sif_rr_arb #(.N(NUM_W)) u_arb (
        .clk (clk),
        .rst (rst),
        .en  (~bus.xa_wr_s),
        .req (busy),
        .gnt (gnt)
    );

    // select the granted holding register for the shared write port
    always_comb begin
        w_addr = '0;
        w_data = '0;
        w_act  = 1'b0;
        for (int i = 0; i < NUM_W; i++) begin
            if (gnt[i]) begin
                w_addr = hold_addr[i];
                w_data = hold_data[i];
                w_act  = 1'b1;
            end
        end
    end

    // read value, optionally bypassing the write landing at the same edge
    always_comb begin
        rd_val = mem[bus.xa_addr[AW-1:0]];
`ifdef SIF_REGBANK_WR_FWD_EN
        rd_val = (we && wr_addr == bus.xa_addr) ? wr_data : rd_val;
`endif
    end

    // W holding registers: capture when free, release on grant
    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= '0;
            hold_addr <= '0;
            hold_data <= '0;
        end else begin
            for (int i = 0; i < NUM_W; i++) begin
                if (gnt[i]) begin
                    busy[i] <= 1'b0;
                end else if (bus.wa_wr_s[i] && !busy[i]) begin
                    busy[i]      <= 1'b1;
                    hold_addr[i] <= bus.wa_addr[i];
                    hold_data[i] <= bus.wa_data_wr[i];
                end
            end
        end
    end

    // register array with a single write port, X has priority
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[wr_addr[AW-1:0]] <= wr_data;
        end
    end

    // X read response and out-of-range error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.xa_data_rd <= '0;
            bus.xa_rd_vld  <= 1'b0;
            bus.xa_err     <= 1'b0;
        end else begin
            bus.xa_rd_vld <= bus.xa_rd_s;
            bus.xa_err    <= (bus.xa_rd_s || bus.xa_wr_s) && !x_in;
            if (bus.xa_rd_s) bus.xa_data_rd <= x_in ? rd_val : '0;
        end
    end
endmodule

// File: tb/tb_sif_regbank.sv
// tb_sif_regbank: directed self-checking bench for sif_regbank
module tb_sif_regbank;
    import sif_regbank_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int total = 0;
    int bad = 0;

    sif_regbank_if #(.NUM_W(2), .ADDR_W(16), .DATA_W(16)) bus ();

    sif_regbank #(.NUM_W(2), .ADDR_W(16), .DATA_W(16), .DEPTH(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic x_write(input logic [15:0] a, input logic [15:0] d);
        bus.xa_wr_s = 1'b1; bus.xa_addr = a; bus.xa_data_wr = d;
        tick();
        bus.xa_wr_s = 1'b0;
    endtask

    task automatic x_read(input logic [15:0] a);
        bus.xa_rd_s = 1'b1; bus.xa_addr = a;
        tick();
        bus.xa_rd_s = 1'b0;
    endtask

    task automatic w_strobe(input logic [1:0] s, input sif_wr_req_t r0, input sif_wr_req_t r1);
        bus.wa_wr_s = s;
        bus.wa_addr[0] = r0.addr; bus.wa_data_wr[0] = r0.data;
        bus.wa_addr[1] = r1.addr; bus.wa_data_wr[1] = r1.data;
    endtask

    task automatic test_reset();
        bus.xa_wr_s = 0; bus.xa_rd_s = 0; bus.xa_addr = 0; bus.xa_data_wr = 0;
        bus.wa_wr_s = 0; bus.wa_addr = '0; bus.wa_data_wr = '0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        total += 4;
        if (bus.xa_rd_vld !== 1'b0) begin bad++; $display("FAIL reset_vld got %b exp 0", bus.xa_rd_vld); end
        if (bus.xa_err !== 1'b0) begin bad++; $display("FAIL reset_err got %b exp 0", bus.xa_err); end
        if (bus.xa_data_rd !== 16'h0) begin bad++; $display("FAIL reset_data got %h exp 0000", bus.xa_data_rd); end
        if (bus.wa_busy !== 2'b00) begin bad++; $display("FAIL reset_busy got %b exp 00", bus.wa_busy); end
    endtask

    task automatic test_read_zero();
        x_read(16'h0005);
        total += 3;
        if (bus.xa_rd_vld !== 1'b1) begin bad++; $display("FAIL rd0_vld got %b exp 1", bus.xa_rd_vld); end
        if (bus.xa_data_rd !== 16'h0000) begin bad++; $display("FAIL rd0_data got %h exp 0000", bus.xa_data_rd); end
        if (bus.xa_err !== 1'b0) begin bad++; $display("FAIL rd0_err got %b exp 0", bus.xa_err); end
        tick();
        total++;
        if (bus.xa_rd_vld !== 1'b0) begin bad++; $display("FAIL rd0_vld_pulse got %b exp 0", bus.xa_rd_vld); end
    endtask

    task automatic test_write_read();
        x_write(16'h0010, 16'hBEEF);
        total++;
        if (bus.xa_err !== 1'b0) begin bad++; $display("FAIL wr_err got %b exp 0", bus.xa_err); end
        x_read(16'h0010);
        total += 2;
        if (bus.xa_rd_vld !== 1'b1) begin bad++; $display("FAIL wr_rd_vld got %b exp 1", bus.xa_rd_vld); end
        if (bus.xa_data_rd !== 16'hBEEF) begin bad++; $display("FAIL wr_rd_data got %h exp beef", bus.xa_data_rd); end
        tick();
        total += 2;
        if (bus.xa_rd_vld !== 1'b0) begin bad++; $display("FAIL wr_rd_vld_low got %b exp 0", bus.xa_rd_vld); end
        if (bus.xa_data_rd !== 16'hBEEF) begin bad++; $display("FAIL wr_rd_hold got %h exp beef", bus.xa_data_rd); end
    endtask

    task automatic test_w_arb();
        w_strobe(2'b11, '{16'h0001, 16'h1111}, '{16'h0002, 16'h2222});
        tick();
        bus.wa_wr_s = 2'b00;
        total++;
        if (bus.wa_busy !== 2'b11) begin bad++; $display("FAIL arb_busy_cap got %b exp 11", bus.wa_busy); end
        tick();
        total++;
        if (bus.wa_busy !== 2'b10) begin bad++; $display("FAIL arb_busy_w0 got %b exp 10", bus.wa_busy); end
        tick();
        total++;
        if (bus.wa_busy !== 2'b00) begin bad++; $display("FAIL arb_busy_w1 got %b exp 00", bus.wa_busy); end
        x_read(16'h0001);
        total++;
        if (bus.xa_data_rd !== 16'h1111) begin bad++; $display("FAIL arb_rd1 got %h exp 1111", bus.xa_data_rd); end
        x_read(16'h0002);
        total++;
        if (bus.xa_data_rd !== 16'h2222) begin bad++; $display("FAIL arb_rd2 got %h exp 2222", bus.xa_data_rd); end
    endtask

    task automatic test_x_starve();
        w_strobe(2'b11, '{16'h0004, 16'h4444}, '{16'h0005, 16'h5555});
        bus.xa_wr_s = 1'b1; bus.xa_addr = 16'h0020; bus.xa_data_wr = 16'h0020;
        tick();
        total++;
        if (bus.wa_busy !== 2'b11) begin bad++; $display("FAIL starve_busy_e1 got %b exp 11", bus.wa_busy); end
        w_strobe(2'b01, '{16'h0004, 16'hDEAD}, '{16'h0005, 16'h5555});
        bus.xa_addr = 16'h0021; bus.xa_data_wr = 16'h0021;
        tick();
        bus.wa_wr_s = 2'b00;
        bus.xa_addr = 16'h0022; bus.xa_data_wr = 16'h0022;
        tick();
        total++;
        if (bus.wa_busy !== 2'b11) begin bad++; $display("FAIL starve_busy_e3 got %b exp 11", bus.wa_busy); end
        bus.xa_wr_s = 1'b0;
        tick();
        total++;
        if (bus.wa_busy !== 2'b10) begin bad++; $display("FAIL starve_busy_e4 got %b exp 10", bus.wa_busy); end
        tick();
        total++;
        if (bus.wa_busy !== 2'b00) begin bad++; $display("FAIL starve_busy_e5 got %b exp 00", bus.wa_busy); end
        x_read(16'h0004);
        total++;
        if (bus.xa_data_rd !== 16'h4444) begin bad++; $display("FAIL starve_rd4 got %h exp 4444", bus.xa_data_rd); end
        x_read(16'h0005);
        total++;
        if (bus.xa_data_rd !== 16'h5555) begin bad++; $display("FAIL starve_rd5 got %h exp 5555", bus.xa_data_rd); end
        x_read(16'h0021);
        total++;
        if (bus.xa_data_rd !== 16'h0021) begin bad++; $display("FAIL starve_rd21 got %h exp 0021", bus.xa_data_rd); end
    endtask

    task automatic test_out_of_range();
        x_read(16'h0040);
        total += 3;
        if (bus.xa_err !== 1'b1) begin bad++; $display("FAIL oor_rd_err got %b exp 1", bus.xa_err); end
        if (bus.xa_rd_vld !== 1'b1) begin bad++; $display("FAIL oor_rd_vld got %b exp 1", bus.xa_rd_vld); end
        if (bus.xa_data_rd !== 16'h0000) begin bad++; $display("FAIL oor_rd_data got %h exp 0000", bus.xa_data_rd); end
        tick();
        total++;
        if (bus.xa_err !== 1'b0) begin bad++; $display("FAIL oor_err_pulse got %b exp 0", bus.xa_err); end
        x_write(16'h0040, 16'h1234);
        total += 2;
        if (bus.xa_err !== 1'b1) begin bad++; $display("FAIL oor_wr_err got %b exp 1", bus.xa_err); end
        if (bus.xa_rd_vld !== 1'b0) begin bad++; $display("FAIL oor_wr_vld got %b exp 0", bus.xa_rd_vld); end
        x_read(16'h0000);
        total++;
        if (bus.xa_data_rd !== 16'h0000) begin bad++; $display("FAIL oor_wr_alias got %h exp 0000", bus.xa_data_rd); end
        w_strobe(2'b01, '{16'h0041, 16'h5678}, '{16'h0000, 16'h0000});
        tick();
        bus.wa_wr_s = 2'b00;
        total++;
        if (bus.wa_busy !== 2'b01) begin bad++; $display("FAIL oor_w_busy got %b exp 01", bus.wa_busy); end
        tick();
        total++;
        if (bus.wa_busy !== 2'b00) begin bad++; $display("FAIL oor_w_clear got %b exp 00", bus.wa_busy); end
        x_read(16'h0001);
        total++;
        if (bus.xa_data_rd !== 16'h1111) begin bad++; $display("FAIL oor_w_alias got %h exp 1111", bus.xa_data_rd); end
    endtask

    task automatic test_rd_wr_same();
        logic [15:0] exp_d;
`ifdef SIF_REGBANK_WR_FWD_EN
        exp_d = 16'h00AA;
`else
        exp_d = 16'h0000;
`endif
        bus.xa_wr_s = 1'b1; bus.xa_rd_s = 1'b1; bus.xa_addr = 16'h0003; bus.xa_data_wr = 16'h00AA;
        tick();
        bus.xa_wr_s = 1'b0; bus.xa_rd_s = 1'b0;
        total += 2;
        if (bus.xa_rd_vld !== 1'b1) begin bad++; $display("FAIL same_vld got %b exp 1", bus.xa_rd_vld); end
        if (bus.xa_data_rd !== exp_d) begin bad++; $display("FAIL same_data got %h exp %h", bus.xa_data_rd, exp_d); end
        x_read(16'h0003);
        total++;
        if (bus.xa_data_rd !== 16'h00AA) begin bad++; $display("FAIL same_after got %h exp 00aa", bus.xa_data_rd); end
    endtask

    task automatic test_reset_midflight();
        w_strobe(2'b10, '{16'h0000, 16'h0000}, '{16'h0006, 16'h6666});
        tick();
        bus.wa_wr_s = 2'b00;
        total++;
        if (bus.wa_busy !== 2'b10) begin bad++; $display("FAIL mid_busy got %b exp 10", bus.wa_busy); end
        rst = 1'b1; bus.xa_rd_s = 1'b1; bus.xa_addr = 16'h0010;
        tick();
        rst = 1'b0; bus.xa_rd_s = 1'b0;
        total += 3;
        if (bus.wa_busy !== 2'b00) begin bad++; $display("FAIL mid_rst_busy got %b exp 00", bus.wa_busy); end
        if (bus.xa_rd_vld !== 1'b0) begin bad++; $display("FAIL mid_rst_vld got %b exp 0", bus.xa_rd_vld); end
        if (bus.xa_data_rd !== 16'h0000) begin bad++; $display("FAIL mid_rst_data got %h exp 0000", bus.xa_data_rd); end
        tick();
        x_read(16'h0010);
        total++;
        if (bus.xa_data_rd !== 16'h0000) begin bad++; $display("FAIL mid_rst_mem got %h exp 0000", bus.xa_data_rd); end
        tick();
        x_read(16'h0006);
        total++;
        if (bus.xa_data_rd !== 16'h0000) begin bad++; $display("FAIL mid_rst_drop got %h exp 0000", bus.xa_data_rd); end
    endtask

    initial begin
        test_reset();
        test_read_zero();
        test_write_read();
        test_w_arb();
        test_x_starve();
        test_out_of_range();
        test_rd_wr_same();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
